// File: rtl/mul_div_unit.sv
// Iterative 32-bit multiply/divide unit owning HI/LO. Each mult/div takes 34 cycles:
// 1 accept, 32 radix-2 steps, 1 sign fix. MF*/MT* are served only while idle.
//   state  | meaning
//   S_IDLE | no computation in flight; MT* writes, MF* reads, mult/div accepted
//   S_CALC | one shift-add or restoring-divide step per cycle, 32 steps
//   S_FIX  | sign correction, HI/LO written at the end of this cycle
module mul_div_unit (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_op_valid,
  input  logic [2:0]  i_op,
  input  logic        i_flush,
  input  logic [31:0] i_rs,
  input  logic [31:0] i_rt,
  output logic        o_busy,
  output logic        o_stall,
  output logic [31:0] o_result,
  output logic        o_result_valid
);

  localparam logic [2:0] OP_MFHI = 3'd4;
  localparam logic [2:0] OP_MFLO = 3'd5;
  localparam logic [2:0] OP_MTHI = 3'd6;
  localparam logic [2:0] OP_MTLO = 3'd7;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

  state_t      state, state_nxt;
  logic [31:0] hi, lo;
  logic [31:0] acc, shift, opnd;
  logic [5:0]  cnt;
  logic        is_div, q_neg, r_neg;

  logic        accept, start_md, signed_op;
  logic [31:0] abs_rs, abs_rt;
  logic [32:0] add_sum, rem_sh, diff;
  logic [63:0] prod_fix;
  logic [31:0] quo_fix, rem_fix;

  assign o_busy         = (state != S_IDLE);
  assign o_stall        = i_op_valid && o_busy;
  assign o_result       = (i_op == OP_MFHI) ? hi : lo;
  assign o_result_valid = i_op_valid && !o_busy && !i_flush &&
                          ((i_op == OP_MFHI) || (i_op == OP_MFLO));

  assign accept    = i_op_valid && !o_busy && !i_flush;
  assign start_md  = accept && !i_op[2];
  assign signed_op = !i_op[2] && !i_op[0];
  assign abs_rs    = (signed_op && i_rs[31]) ? (~i_rs + 32'd1) : i_rs;
  assign abs_rt    = (signed_op && i_rt[31]) ? (~i_rt + 32'd1) : i_rt;

  // Multiply: {acc,shift} holds partial product over multiplier bits.
  // Divide: acc is the partial remainder, shift shifts dividend out and quotient in.
  assign add_sum  = {1'b0, acc} + {1'b0, opnd};
  assign rem_sh   = {acc, shift[31]};
  assign diff     = rem_sh - {1'b0, opnd};
  assign prod_fix = q_neg ? (~{acc, shift} + 64'd1) : {acc, shift};
  assign quo_fix  = q_neg ? (~shift + 32'd1) : shift;
  assign rem_fix  = r_neg ? (~acc + 32'd1) : acc;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start_md) state_nxt = S_CALC;
      S_CALC:  if (cnt == 6'd1) state_nxt = S_FIX;
      S_FIX:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      hi     <= '0;
      lo     <= '0;
      acc    <= '0;
      shift  <= '0;
      opnd   <= '0;
      cnt    <= '0;
      is_div <= 1'b0;
      q_neg  <= 1'b0;
      r_neg  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_md) begin
            acc    <= '0;
            shift  <= abs_rs;
            opnd   <= abs_rt;
            cnt    <= 6'd32;
            is_div <= i_op[1];
            // A zero divisor leaves the quotient unsigned all-ones and the
            // remainder equal to the dividend once its sign is restored.
            q_neg  <= signed_op && (i_rs[31] ^ i_rt[31]) && !(i_op[1] && (i_rt == 32'd0));
            r_neg  <= signed_op && i_rs[31];
          end else if (accept && (i_op == OP_MTHI)) begin
            hi <= i_rs;
          end else if (accept && (i_op == OP_MTLO)) begin
            lo <= i_rs;
          end
        end
        S_CALC: begin
          cnt <= cnt - 6'd1;
          if (is_div) begin
            if (!diff[32]) begin
              acc   <= diff[31:0];
              shift <= {shift[30:0], 1'b1};
            end else begin
              acc   <= rem_sh[31:0];
              shift <= {shift[30:0], 1'b0};
            end
          end else if (shift[0]) begin
            {acc, shift} <= {add_sum, shift[31:1]};
          end else begin
            {acc, shift} <= {1'b0, acc, shift[31:1]};
          end
        end
        S_FIX: begin
          if (is_div) begin
            hi <= rem_fix;
            lo <= quo_fix;
          end else begin
            {hi, lo} <= prod_fix;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Bench for mul_div_unit: arithmetic reference model of HI/LO and busy timing,
// a per-cycle compare process, and directed vectors with literal expectations.
module tb_mul_div_unit;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_op_valid = 1'b0;
  logic [2:0]  i_op = 3'd0;
  logic        i_flush = 1'b0;
  logic [31:0] i_rs = '0;
  logic [31:0] i_rt = '0;
  logic        o_busy, o_stall, o_result_valid;
  logic [31:0] o_result;

  localparam logic [2:0] MULT = 3'd0, MULTU = 3'd1, DIV = 3'd2, DIVU = 3'd3,
                         MFHI = 3'd4, MFLO = 3'd5, MTHI = 3'd6, MTLO = 3'd7;

  int n_tests = 0;
  int n_fail  = 0;

  mul_div_unit dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_op_valid(i_op_valid), .i_op(i_op),
    .i_flush(i_flush), .i_rs(i_rs), .i_rt(i_rt), .o_busy(o_busy),
    .o_stall(o_stall), .o_result(o_result), .o_result_valid(o_result_valid)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic on plain integers.
  function automatic void calc(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                               output logic [31:0] hi, output logic [31:0] lo);
    longint sa, sb, sp;
    logic [63:0] up;
    int q, r;
    hi = '0; lo = '0;
    case (op)
      MULT: begin
        sa = longint'($signed(a)); sb = longint'($signed(b)); sp = sa * sb;
        {hi, lo} = sp;
      end
      MULTU: begin
        up = {32'd0, a} * {32'd0, b};
        {hi, lo} = up;
      end
      DIV: begin
        if (b == 32'd0) begin lo = 32'hFFFF_FFFF; hi = a; end
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin lo = 32'h8000_0000; hi = 32'd0; end
        else begin q = $signed(a) / $signed(b); r = $signed(a) % $signed(b); lo = q; hi = r; end
      end
      DIVU: begin
        if (b == 32'd0) begin lo = 32'hFFFF_FFFF; hi = a; end
        else begin lo = a / b; hi = a % b; end
      end
      default: ;
    endcase
  endfunction

  logic [31:0] m_hi, m_lo, p_hi, p_lo;
  int busy_left;

  always @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      m_hi = '0; m_lo = '0; p_hi = '0; p_lo = '0; busy_left = 0;
    end else if (busy_left > 0) begin
      busy_left--;
      if (busy_left == 0) begin m_hi = p_hi; m_lo = p_lo; end
    end else if (i_op_valid && !i_flush) begin
      case (i_op)
        MULT, MULTU, DIV, DIVU: begin calc(i_op, i_rs, i_rt, p_hi, p_lo); busy_left = 33; end
        MTHI: m_hi = i_rs;
        MTLO: m_lo = i_rs;
        default: ;
      endcase
    end
  end

  always @(negedge i_clk) begin
    logic eb, ev;
    eb = (busy_left != 0);
    ev = i_op_valid && !eb && !i_flush && (i_op == MFHI || i_op == MFLO);
    check("busy", 32'(o_busy), 32'(eb));
    check("stall", 32'(o_stall), 32'(i_op_valid && eb));
    check("result_valid", 32'(o_result_valid), 32'(ev));
    if (ev) check("result", o_result, (i_op == MFHI) ? m_hi : m_lo);
  end

  // Presents an op and holds it (as EXE would) until the cycle it is accepted.
  task automatic issue(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt);
    int n;
    bit done;
    i_op_valid = 1'b1; i_op = op; i_rs = rs; i_rt = rt; n = 0; done = 1'b0;
    while (!done && n < 200) begin
      @(negedge i_clk);
      done = !o_busy && !i_flush;
      @(posedge i_clk); #1;
      n++;
    end
    if (!done) begin
      n_tests++; n_fail++;
      $display("FAIL issue_timeout: op %0d not accepted within %0d cycles", op, n);
    end
    i_op_valid = 1'b0; i_rs = $urandom(); i_rt = $urandom();
  endtask

  task automatic read_mf(input logic [2:0] op, input logic [31:0] exp, input string name,
                         output int stalls);
    int n;
    bit done;
    i_op_valid = 1'b1; i_op = op; n = 0; done = 1'b0; stalls = 0;
    while (!done && n < 200) begin
      @(negedge i_clk);
      if (!o_busy) begin
        check(name, o_result, exp);
        check({"model_", name}, (op == MFHI) ? m_hi : m_lo, exp);
        done = 1'b1;
      end else begin
        stalls++;
      end
      @(posedge i_clk); #1;
      n++;
    end
    if (!done) begin
      n_tests++; n_fail++;
      $display("FAIL %s_timeout: no result within %0d cycles", name, n);
    end
    i_op_valid = 1'b0;
  endtask

  initial begin
    int st;
    repeat (3) @(posedge i_clk);
    #2 i_rst_n = 1'b1;
    @(negedge i_clk);
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_stall", 32'(o_stall), 32'd0);
    check("rst_result", o_result, 32'd0);
    @(posedge i_clk); #1;
    read_mf(MFLO, 32'd0, "rst_mflo", st);

    issue(MULT, 32'hFFFF_FFFE, 32'd3);
    read_mf(MFHI, 32'hFFFF_FFFF, "mult_hi", st);
    check("mult_stall_cycles", 32'(st), 32'd33);
    read_mf(MFLO, 32'hFFFF_FFFA, "mult_lo", st);

    issue(MULTU, 32'hFFFF_FFFE, 32'd3);
    read_mf(MFHI, 32'h0000_0002, "multu_hi", st);
    read_mf(MFLO, 32'hFFFF_FFFA, "multu_lo", st);

    issue(DIV, 32'hFFFF_FFF9, 32'd2);
    read_mf(MFLO, 32'hFFFF_FFFD, "div_lo", st);
    read_mf(MFHI, 32'hFFFF_FFFF, "div_hi", st);

    issue(DIVU, 32'd7, 32'd0);
    read_mf(MFLO, 32'hFFFF_FFFF, "divu0_lo", st);
    read_mf(MFHI, 32'd7, "divu0_hi", st);

    issue(DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    read_mf(MFLO, 32'h8000_0000, "divovf_lo", st);
    read_mf(MFHI, 32'd0, "divovf_hi", st);

    issue(DIV, 32'h0000_0009, 32'd0);
    read_mf(MFLO, 32'hFFFF_FFFF, "div0_lo", st);
    read_mf(MFHI, 32'd9, "div0_hi", st);

    issue(MTLO, 32'h1234_5678, 32'd0);
    read_mf(MFLO, 32'h1234_5678, "mtlo", st);
    check("mtlo_no_stall", 32'(st), 32'd0);

    issue(MULT, 32'd5, 32'd6);
    issue(MTHI, 32'hAAAA_5555, 32'd0);
    read_mf(MFHI, 32'hAAAA_5555, "mthi_busy", st);
    read_mf(MFLO, 32'd30, "mult56_lo", st);

    i_op_valid = 1'b1; i_op = MULT; i_flush = 1'b1; i_rs = 32'd9; i_rt = 32'd9;
    @(posedge i_clk); #1;
    i_op_valid = 1'b0; i_flush = 1'b0;
    @(negedge i_clk);
    check("flush_no_busy", 32'(o_busy), 32'd0);
    @(posedge i_clk); #1;
    read_mf(MFHI, 32'hAAAA_5555, "flush_hi", st);
    read_mf(MFLO, 32'd30, "flush_lo", st);

    issue(DIVU, 32'd100, 32'd7);
    i_flush = 1'b1; i_op_valid = 1'b1; i_op = MULT;
    repeat (5) @(posedge i_clk);
    #1 i_flush = 1'b0; i_op_valid = 1'b0;
    read_mf(MFLO, 32'd14, "flush_calc_lo", st);
    read_mf(MFHI, 32'd2, "flush_calc_hi", st);

    issue(DIV, 32'd1000, 32'hFFFF_FFFD);
    repeat (9) @(posedge i_clk);
    #2 i_rst_n = 1'b0;
    #1 i_op = MFHI;
    #1 check("arst_busy", 32'(o_busy), 32'd0);
    check("arst_hi", o_result, 32'd0);
    i_op = MFLO;
    #1 check("arst_lo", o_result, 32'd0);
    @(posedge i_clk); #3 i_rst_n = 1'b1;
    @(posedge i_clk); #1;
    issue(DIV, 32'hFFFF_FC18, 32'd3);
    read_mf(MFLO, 32'hFFFF_FEB3, "post_rst_lo", st);
    check("post_rst_stall_cycles", 32'(st), 32'd33);
    read_mf(MFHI, 32'hFFFF_FFFF, "post_rst_hi", st);

    issue(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    issue(MULT, 32'h8000_0000, 32'h8000_0000);
    read_mf(MFHI, 32'h4000_0000, "b2b_hi", st);
    read_mf(MFLO, 32'd0, "b2b_lo", st);

    repeat (2) @(posedge i_clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

Iterative multiply/divide unit in the EXE stage, owning the HI/LO register pair. It accepts MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO from the EXE instruction and runs multiply and divide over 34 cycles. It produces the MFHI/MFLO result that feeds the EXE write-data/forwarding path (EXE wdata and get-result-in-EXE). It stalls the pipeline whenever an MDU instruction arrives while a computation is in flight.

## Interface
- No parameters (data width fixed at 32).
- i_clk  input  1  clock, all state updates on rising edge
- i_rst_n  input  1  asynchronous active-low reset
- i_op_valid  input  1  EXE instruction is an MDU op
- i_op  input  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MFHI, 5 MFLO, 6 MTHI, 7 MTLO
- i_flush  input  1  EXE instruction is being cancelled; suppresses acceptance
- i_rs  input  32  operand A / dividend / MTHI-MTLO data
- i_rt  input  32  operand B / divisor
- o_busy  output  1  state != IDLE
- o_stall  output  1  i_op_valid && o_busy (combinational)
- o_result  output  32  HI when i_op==MFHI, else LO (combinational)
- o_result_valid  output  1  i_op_valid && !o_busy && i_op∈{MFHI,MFLO} && !i_flush

## Operation
- Registers: HI, LO, 64-bit working pair (acc, shift), 32-bit operand copy, 6-bit counter, result-sign flags, state.
- Accept = i_op_valid && !o_busy && !i_flush at a rising edge.
- States: IDLE, CALC, FIX.
  - IDLE + accept MULT/MULTU/DIV/DIVU → latch magnitudes (signed ops: two's-complement absolute value; unsigned: raw) and sign flags, counter←32, go to CALC.
  - IDLE + accept MTHI/MTLO → HI (resp. LO) ← i_rs at that edge, stay IDLE.
  - IDLE + MFHI/MFLO → no state change; data via o_result.
  - CALC: one radix-2 step per cycle (shift-add multiply; restoring divide). Counter decrements; at counter==1 go to FIX.
  - FIX: apply sign correction and write HI/LO at the edge ending FIX, go to IDLE.
- Multiply: {HI,LO} = full 64-bit product, signed or unsigned per op.
- Divide: LO = quotient truncated toward zero, HI = remainder with sign of dividend.
- Divide by zero (either signedness): LO=0xFFFFFFFF, HI=dividend.
- Signed overflow (0x80000000 / 0xFFFFFFFF): LO=0x80000000, HI=0.
- i_flush never aborts a computation already in CALC/FIX.
- Operands are captured at acceptance only; i_rs/i_rt are don't-care while busy.
- Reset (asynchronous, any state including mid-CALC): state IDLE, HI=LO=0, counter=0, working regs 0. Outputs after reset: o_busy=0, o_stall=0 with i_op_valid=0, o_result=0.

## Timing
- Mult/div accepted at edge ending cycle T:
  - CALC occupies cycles T+1..T+32.
  - FIX is cycle T+33; HI/LO are updated at the edge ending T+33.
  - o_busy is high T+1..T+33 and low from T+34.
- Non-MDU instructions are never stalled by a busy MDU.
- Any MDU op presented during busy: o_stall=1 every such cycle. The EXE stage holds the instruction; it is accepted (MT*) or served (MF*) in the first cycle with o_busy=0.
- MFHI/MFLO in T+34 returns the new value (no stale read).
- MTHI/MTLO latency 1: MFLO in the cycle after MTLO sees the new LO.
- Back-to-back MULT at T+34 is accepted; the previous HI/LO remain visible until its FIX edge.

## Test plan
- Reset then MFLO: o_result_valid=1, o_result=0, o_stall=0.
- MULT rs=0xFFFFFFFE (-2), rt=3 at T → o_busy high T+1..T+33. MFHI presented from T+1 stalls until T+34, then returns 0xFFFFFFFF; MFLO returns 0xFFFFFFFA. MULTU same operands → HI=0x00000002, LO=0xFFFFFFFA.
- DIV -7/2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 7/0 → LO=0xFFFFFFFF, HI=7. DIV 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0.
- MTLO 0x12345678 then MFLO next cycle → 0x12345678. MTHI issued during busy stalls; it takes effect after the mult completes and is not overwritten by it.
- i_flush with MULT valid → no acceptance, o_busy stays 0, HI/LO unchanged. i_flush during CALC → computation completes normally.
- Assert i_rst_n=0 asynchronously at T+10 of a DIV → o_busy=0 immediately, HI=LO=0; a new DIV after release completes in 34 cycles with correct result.
